tx_update_arbiter: RTL and testbench

Merges per-processor update FIFOs into the single external transmit update FIFO feeding the Ethernet TX path, the outbound counterpart of the RX-side update distributor. Requesters are served round-robin in bursts of up to BURST_LEN words, so one busy processor cannot starve the others. The block drives read requests into non-show-ahead processor FIFOs and write requests into the TX FIFO. It honours TX back-pressure without dropping or duplicating words.

---
 rtl/tx_arb_pkg.sv | 16 +
 rtl/tx_update_arbiter_rr_pick.sv | 31 +++
 rtl/tx_update_arbiter.sv | 103 ++++++++++
 tb/tb_tx_update_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arb_pkg.sv
// Shared types and helpers for the TX update arbiter and its round-robin finder.
package tx_arb_pkg;

  typedef enum logic {IDLE, BURST} arb_state_t;

  localparam int STAT_W = 32;

  // Ceiling log2 with a floor of 1 so single-bit indices stay legal.
  function automatic int log2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/tx_update_arbiter_rr_pick.sv
// Combinational round-robin finder: first set request bit after index last, wrapping.
module rr_pick
  import tx_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]       req,
  input  logic [log2(N)-1:0] last,
  output logic               found,
  output logic [log2(N)-1:0] idx
);

  localparam int IW = log2(N);

  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    idx   = '0;
    // Offset 1 first so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      j = int'(last) + k;
      if (j >= N) j -= N;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/tx_update_arbiter.sv
// Round-robin burst arbiter merging per-processor update FIFOs into the TX update FIFO.
// Define TX_ARB_STATS_EN to build the per-requester forwarded-word counters.
module tx_update_arbiter
  import tx_arb_pkg::*;
#(
  parameter int NUM_PROCS = 2,
  parameter int DATA_W    = 64,
  parameter int BURST_LEN = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_PROCS*DATA_W-1:0] proc_q,
  input  logic [NUM_PROCS-1:0]        proc_empty,
  output logic [NUM_PROCS-1:0]        proc_rdreq,
  output logic [DATA_W-1:0]           tx_data,
  output logic                        tx_wrreq,
  input  logic                        tx_afull,
  output logic [log2(NUM_PROCS)-1:0]  tx_src,
  output logic [NUM_PROCS*STAT_W-1:0] stat_words
);

  localparam int SRC_W = log2(NUM_PROCS);
  localparam int CNT_W = log2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [SRC_W-1:0] SRC_TOP  = SRC_W'(NUM_PROCS - 1);

  arb_state_t       state;
  logic [SRC_W-1:0] grant;
  logic [SRC_W-1:0] last;
  logic [SRC_W-1:0] pick_idx;
  logic [CNT_W-1:0] cnt;
  logic             pick_found;
  logic             rd_now;

  rr_pick #(.N(NUM_PROCS)) u_pick (
    .req   (~proc_empty),
    .last  (last),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Pop stage: read is gated by afull so at most one word is ever in flight.
  assign rd_now = (state == BURST) && !proc_empty[grant] && !tx_afull &&
                  (cnt < CNT_MAX) && !reset;

  always_comb begin
    proc_rdreq        = '0;
    proc_rdreq[grant] = rd_now;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      last     <= SRC_TOP;
      cnt      <= '0;
      tx_wrreq <= 1'b0;
      tx_src   <= '0;
    end else begin
      tx_wrreq <= |proc_rdreq;
      tx_src   <= grant;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant <= pick_idx;
            cnt   <= '0;
            state <= BURST;
          end
        end
        BURST: begin
          if (rd_now) cnt <= cnt + 1'b1;
          if (proc_empty[grant] || (rd_now && cnt == CNT_LAST)) begin
            last  <= grant;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Write stage: the non-show-ahead FIFO presents the popped word one cycle after the read.
  assign tx_data = proc_q[int'(tx_src)*DATA_W +: DATA_W];

`ifdef TX_ARB_STATS_EN
  logic [STAT_W-1:0] stat_cnt [NUM_PROCS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PROCS; i++) begin
      if (reset) stat_cnt[i] <= '0;
      else if (tx_wrreq && tx_src == SRC_W'(i)) stat_cnt[i] <= stat_cnt[i] + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_PROCS; g++) begin : g_stat
    assign stat_words[g*STAT_W +: STAT_W] = stat_cnt[g];
  end
`else
  assign stat_words = '0;
`endif

endmodule

// File: tb/tb_tx_update_arbiter.sv
// Directed self-checking bench for tx_update_arbiter with behavioural non-show-ahead FIFOs.
module tb_tx_update_arbiter;

  localparam int NP = 2;
  localparam int DW = 64;

  logic               clk = 1'b0;
  logic               reset;
  logic [NP*DW-1:0]   proc_q;
  logic [NP-1:0]      proc_empty;
  logic [NP-1:0]      proc_rdreq;
  logic [DW-1:0]      tx_data;
  logic               tx_wrreq;
  logic               tx_afull;
  logic [0:0]         tx_src;
  logic [NP*32-1:0]   stat_words;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tx_update_arbiter #(.NUM_PROCS(NP), .DATA_W(DW), .BURST_LEN(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .proc_q     (proc_q),
    .proc_empty (proc_empty),
    .proc_rdreq (proc_rdreq),
    .tx_data    (tx_data),
    .tx_wrreq   (tx_wrreq),
    .tx_afull   (tx_afull),
    .tx_src     (tx_src),
    .stat_words (stat_words)
  );

  // Processor FIFO models
  logic [DW-1:0] mem [NP][64];
  logic [DW-1:0] q_reg [NP];
  int wr_ptr [NP] = '{0, 0};
  int rd_ptr [NP] = '{0, 0};

  for (genvar p = 0; p < NP; p++) begin : g_fifo
    assign proc_q[p*DW +: DW] = q_reg[p];
    assign proc_empty[p]      = (wr_ptr[p] == rd_ptr[p]);
  end

  always @(posedge clk)
    for (int p = 0; p < NP; p++)
      if (proc_rdreq[p] && (wr_ptr[p] != rd_ptr[p])) begin
        q_reg[p]  <= mem[p][rd_ptr[p]];
        rd_ptr[p] <= rd_ptr[p] + 1;
      end

  // Write monitor
  int cyc = 0;
  int underflow = 0;
  int afull_reads = 0;
  int log_src [$];
  logic [DW-1:0] log_data [$];
  int log_cyc [$];
  int exp_q [$];
  int exp_gap [$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (tx_wrreq) begin
      log_src.push_back(int'(tx_src));
      log_data.push_back(tx_data);
      log_cyc.push_back(cyc);
    end
    for (int p = 0; p < NP; p++)
      if (proc_rdreq[p] && proc_empty[p]) underflow = underflow + 1;
    if (tx_afull && (|proc_rdreq)) afull_reads = afull_reads + 1;
  end

  function automatic logic [63:0] wd(int p, int k);
    return {32'hA000_0000 + 32'(p), 32'(k)};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(int p);
    mem[p][wr_ptr[p]] = wd(p, wr_ptr[p]);
    wr_ptr[p]++;
  endtask

  task automatic begin_scn();
    reset = 1'b1;
    tx_afull = 1'b0;
    step(2);
    log_src.delete();
    log_data.delete();
    log_cyc.delete();
  endtask

  task automatic wait_rd(string tag, int p, int target);
    int n;
    n = 0;
    while (rd_ptr[p] < target && n < 50) begin
      step(1);
      n++;
    end
    chk(tag, 64'(rd_ptr[p] >= target), 64'd1);
  endtask

  task automatic check_log(string tag, int base0, int base1);
    int idx [NP];
    idx[0] = base0;
    idx[1] = base1;
    chk({tag, "_len"}, 64'(log_src.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_src.size(); i++) begin
      chk({tag, "_src"}, 64'(log_src[i]), 64'(exp_q[i]));
      chk({tag, "_data"}, log_data[i], wd(exp_q[i], idx[exp_q[i]]));
      idx[exp_q[i]]++;
    end
  endtask

  task automatic check_gaps(string tag);
    for (int i = 1; i < log_cyc.size() && i <= exp_gap.size(); i++)
      chk({tag, "_gap"}, 64'(log_cyc[i] - log_cyc[i-1]), 64'(exp_gap[i-1]));
  endtask

  initial begin
    int b0, b1;
    reset = 1'b1;
    tx_afull = 1'b0;
    step(3);
    @(negedge clk);
    chk("rst_wrreq", 64'(tx_wrreq), 64'd0);
    chk("rst_src", 64'(tx_src), 64'd0);
    chk("rst_rdreq", 64'(proc_rdreq), 64'd0);
    chk("rst_stat", 64'(stat_words), 64'd0);

    // All requesters empty: no reads, no writes.
    step(1);
    reset = 1'b0;
    step(5);
    @(negedge clk);
    chk("idle_rdreq", 64'(proc_rdreq), 64'd0);
    chk("idle_wrreq", 64'(tx_wrreq), 64'd0);

    // Single requester, three words.
    begin_scn();
    b0 = wr_ptr[0]; b1 = wr_ptr[1];
    repeat (3) push(0);
    reset = 1'b0;
    step(15);
    exp_q = '{0, 0, 0};
    exp_gap = '{1, 1};
    check_log("single", b0, b1);
    check_gaps("single");
    chk("single_reads", 64'(rd_ptr[0] - b0), 64'd3);

    // Fairness: ten words each.
    begin_scn();
    b0 = wr_ptr[0]; b1 = wr_ptr[1];
    repeat (10) begin push(0); push(1); end
    reset = 1'b0;
    step(70);
    exp_q = '{0,0,0,0, 1,1,1,1, 0,0,0,0, 1,1,1,1, 0,0, 1,1};
    exp_gap = '{1,1,1,2, 1,1,1,2, 1,1,1,2, 1,1,1,2, 1,3, 1};
    check_log("fair", b0, b1);
    check_gaps("fair");

    // Back-pressure for five cycles after two reads.
    begin_scn();
    b0 = wr_ptr[0]; b1 = wr_ptr[1];
    repeat (4) push(0);
    reset = 1'b0;
    wait_rd("bp_wait", 0, b0 + 2);
    tx_afull = 1'b1;
    @(negedge clk);
    chk("bp_inflight", 64'(tx_wrreq), 64'd1);
    step(5);
    tx_afull = 1'b0;
    step(12);
    exp_q = '{0, 0, 0, 0};
    exp_gap = '{1, 6, 1};
    check_log("bp", b0, b1);
    check_gaps("bp");
    chk("bp_afull_reads", 64'(afull_reads), 64'd0);
    chk("bp_reads", 64'(rd_ptr[0] - b0), 64'd4);

    // Requester empties mid-burst, arbiter moves on.
    begin_scn();
    b0 = wr_ptr[0]; b1 = wr_ptr[1];
    push(1);
    reset = 1'b0;
    wait_rd("emp_wait", 1, b1 + 1);
    push(0);
    push(0);
    step(15);
    exp_q = '{1, 0, 0};
    check_log("emp", b0, b1);
    chk("emp_reads1", 64'(rd_ptr[1] - b1), 64'd1);

    // Reset the cycle after the second read of a burst.
    begin_scn();
    b0 = wr_ptr[0]; b1 = wr_ptr[1];
    repeat (4) push(0);
    reset = 1'b0;
    wait_rd("rst_wait", 0, b0 + 2);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_wrreq", 64'(tx_wrreq), 64'd1);
    chk("mid_data", tx_data, wd(0, b0 + 1));
    chk("mid_rdreq", 64'(proc_rdreq), 64'd0);
    step(2);
    chk("mid_noread", 64'(rd_ptr[0] - b0), 64'd2);
    push(1);
    push(1);
    reset = 1'b0;
    step(20);
    exp_q = '{0, 0, 0, 0, 1, 1};
    check_log("mid", b0, b1);

`ifdef TX_ARB_STATS_EN
    begin_scn();
    repeat (7) push(1);
    reset = 1'b0;
    step(30);
    chk("stat_p1", 64'(stat_words[63:32]), 64'd7);
    chk("stat_p0", 64'(stat_words[31:0]), 64'd0);
    reset = 1'b1;
    step(1);
    @(negedge clk);
    chk("stat_clr", 64'(stat_words), 64'd0);
`else
    chk("stat_off", 64'(stat_words), 64'd0);
`endif

    chk("underflow", 64'(underflow), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
